// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the sequential shift unit
// Purpose: operation and FSM state types used by seq_shift_unit and shift_step.
// Ports: none (package).
// Configuration: ROTATE_EN selects whether ROR has a datapath (see seq_shift_unit).
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational partial shift by 0..STEP bits
// Purpose: one iteration of the sequential shifter; shifts data_i by k_i for op_i.
// Ports:
//   data_i  in  XLEN  value to shift
//   k_i     in  KW    shift distance this cycle (0..STEP)
//   op_i    in  2     shift_op_e operation
//   data_o  out XLEN  shifted value
// Configuration: ROTATE_EN adds the rotate-right path; otherwise ROR passes data through.
module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [KW-1:0]   k_i,
  input  shift_op_e       op_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      SLL:     data_o = data_i << k_i;
      SRL:     data_o = data_i >> k_i;
      SRA:     data_o = $signed(data_i) >>> k_i;
`ifdef ROTATE_EN
      // a left shift by XLEN yields zero, so k_i == 0 leaves the value intact
      ROR:     data_o = (data_i >> k_i) | (data_i << (XLEN - int'(k_i)));
`endif
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle SLL/SRL/SRA(/ROR) shift unit with valid/ready
// Purpose: accepts one shift per handshake, iterates up to STEP bits per cycle,
//          and holds the result until the consumer takes it.
// Ports:
//   clk        in  1     rising-edge clock
//   rst        in  1     synchronous active-high reset
//   in_valid   in  1     operation request
//   in_ready   out 1     unit idle and able to accept
//   a          in  XLEN  operand
//   shamt      in  SHW   shift amount (unsigned)
//   op         in  2     00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  out 1     result available
//   out_ready  in  1     consumer takes result
//   result     out XLEN  shifted value
// Configuration: define ROTATE_EN to enable rotate-right; when undefined op=11
//                behaves as a zero-distance shift and no rotate logic is built.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int STEP = 1,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  shamt,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int KW = $clog2(STEP + 1);

  shift_state_e    state_q, state_d;
  shift_op_e       op_q, op_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [SHW-1:0]  shamt_eff;
  logic [KW-1:0]   k;
  logic [XLEN-1:0] step_out;

`ifdef ROTATE_EN
  assign shamt_eff = shamt;
`else
  // no rotate datapath: an ROR request completes as a pass-through of a
  assign shamt_eff = (shift_op_e'(op) == ROR) ? '0 : shamt;
`endif

  // distance for this iteration: min(rem, STEP)
  always_comb begin
    if (int'(rem_q) >= STEP) k = KW'(STEP);
    else                     k = KW'(rem_q);
  end

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP),
    .KW   (KW)
  ) u_step (
    .data_i (work_q),
    .k_i    (k),
    .op_i   (op_q),
    .data_o (step_out)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = a;
          op_d    = shift_op_e'(op);
          rem_d   = shamt_eff;
          state_d = (shamt_eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = step_out;
        rem_d  = rem_q - SHW'(k);
        if (rem_q == SHW'(k)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= SLL;
      work_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
    end
  end

  // work_q only changes in IDLE/SHIFT, so result is frozen while out_valid is high
  assign result = work_q;

endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle, parametrised shift unit for the processor's execute stage. It takes over from the single-cycle combinational shifter for configurations where a full barrel shifter does not fit the area or timing budget. Each operation is accepted through a valid/ready handshake, iterated in steps of up to STEP bits per cycle, and held on a valid/ready output until consumed. It supports SLL, SRL and SRA, plus optional rotate.

## Interface
Parameters:
- XLEN, default 32: datapath width (32 or 64).
- STEP, default 1: maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ XLEN.
- SHW, default $clog2(XLEN): shift-amount width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation.
- a  in  XLEN  operand.
- shamt  in  SHW  shift amount; used unsigned, no masking beyond width.
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  shifted value.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid is high, capture a, op and shamt into the working register, op register and remaining counter rem.
  - Go to DONE if the effective shamt is 0; otherwise go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle, shift the working register by k = min(rem, STEP) and set rem -= k.
  - When rem reaches 0, go to DONE.
- DONE:
  - out_valid=1, in_ready=0, result = working register.
  - When out_ready is high, go to IDLE.
  - A new request is never accepted in the same cycle as an output handshake.
- Fill rules:
  - SLL fills with 0 from the LSB.
  - SRL fills with 0 from the MSB.
  - SRA replicates bit XLEN-1 of the working register.
  - ROR moves the low bits into the top.
- The result equals the ideal single-shot shift of a by shamt for every shamt in 0..XLEN-1.
- Inputs a, shamt and op are ignored outside the IDLE accept cycle; changing them mid-operation has no effect.
- result is stable and unchanged for the whole time out_valid is high.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, rem=0.
- Reset mid-operation aborts the operation and discards it. No output handshake occurs, and the unit is in IDLE on the cycle after rst deasserts.
- Latency: with acceptance on edge 0, out_valid is high from cycle 1+ceil(shamt/STEP).
  - shamt=0 gives latency 1.
  - STEP=XLEN always gives latency 2, or 1 for shamt=0.
- Throughput: one operation per (latency+1) cycles when out_ready is held high.
- Backpressure: DONE holds indefinitely while out_ready is low.
- out_ready is a don't-care outside DONE.

## Configuration
- ROTATE_EN defined: op=11 performs rotate-right by shamt, with the same latency rules as the other ops.
- ROTATE_EN undefined:
  - op=11 is treated as shamt=0, giving result=a with latency 1.
  - The rotate datapath is not synthesised.

## Structure
- Package shift_pkg holds:
  - enum shift_op_e (SLL, SRL, SRA, ROR)
  - enum shift_state_e (IDLE, SHIFT, DONE)
- Sub-module shift_step: combinational shift of an XLEN-bit value by k (0..STEP) for a given op. It is instantiated once, and the FSM, counter and registers live in seq_shift_unit.

## Test plan
- XLEN=32, STEP=1, SLL a=0x0000_0001, shamt=31 -> result 0x8000_0000; out_valid first high in cycle 32.
- STEP=1, a=0x8000_0000, shamt=4 -> SRA gives 0xF800_0000, SRL gives 0x0800_0000; each has latency 5.
- STEP=4, SLL a=0x0000_00FF, shamt=7 -> result 0x0000_7F80 in cycle 3; shamt=0 -> result=a in cycle 1.
- Backpressure: out_ready held low 5 cycles after out_valid -> result stable, in_ready=0; in_valid pulses during the stall are not accepted.
- rst asserted during SHIFT (SLL shamt=20, STEP=1, cycle 10) -> next cycle in IDLE, out_valid=0, result=0; a subsequent op completes correctly.
- ROTATE_EN defined: ROR a=0x0000_0001, shamt=1 -> 0x8000_0000. ROTATE_EN undefined: op=11, a=0x1234_5678, shamt=9 -> result 0x1234_5678 in cycle 1.
